// File: rtl/slv_pkg.sv
// Shared types and default parameter values for the param_slave register-file slave.
package slv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } slv_state_e;

  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_BASE_ADDR   = 0;
  localparam int unsigned DEF_WAIT_STATES = 2;

  // Word-index width; a single-word array still needs one index bit.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/slv_mem_array.sv
// DEPTH x DATA_W register file: synchronous write and clear, combinational read.
module slv_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Guard against indices past DEPTH when DEPTH is not a power of two.
  always_comb begin
    rdata = '0;
    if (32'(idx) < DEPTH) begin
      rdata = mem[idx];
    end
  end

endmodule

// File: rtl/param_slave.sv
// Single-port request/response slave with programmable wait states and address window.
module param_slave
  import slv_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] DataToSlave,
  output logic [DATA_W-1:0] DataFromSlave,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int unsigned IDX_W = idx_w(DEPTH);
  // One extra bit so BASE_ADDR+DEPTH cannot wrap at the top of the address space.
  localparam logic [ADDR_W:0] LO_ADDR = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] HI_ADDR = LO_ADDR + (ADDR_W+1)'(DEPTH);

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rdata;
  logic              we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && sel) begin
        rw_q    <= RW;
        addr_q  <= addr;
        wdata_q <= DataToSlave;
      end
    end
  end

  assign in_range = ({1'b0, addr_q} >= LO_ADDR) && ({1'b0, addr_q} < HI_ADDR);
  assign idx      = IDX_W'(addr_q - ADDR_W'(BASE_ADDR));
  assign we       = (state_q == RESP) && rw_q && in_range;

  slv_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .clr   (rst),
    .we    (we),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  always_comb begin
    ready         = (state_q == RESP);
    busy          = (state_q != IDLE);
    err           = ready && !in_range;
    DataFromSlave = '0;
    if (ready && !rw_q && in_range) begin
      DataFromSlave = rdata;
    end
  end

endmodule

// File: tb/tb_param_slave.sv
// Directed bench for param_slave across four parameterisations sharing clk/rst.
module tb_param_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] dout_a, dout_b, dout_c;
  logic [15:0] dout_d;
  logic [3:0]  rdy, er, bz;

  int unsigned cur;
  logic        rdy_m, err_m, bz_m;
  logic [31:0] dout_m;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // 0: defaults, WAIT_STATES=2
  param_slave #(.WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst), .sel(sel[0]), .RW(rw), .addr(addr), .DataToSlave(wdata),
    .DataFromSlave(dout_a), .ready(rdy[0]), .err(er[0]), .busy(bz[0])
  );
  // 1: no wait states
  param_slave #(.WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .sel(sel[1]), .RW(rw), .addr(addr), .DataToSlave(wdata),
    .DataFromSlave(dout_b), .ready(rdy[1]), .err(er[1]), .busy(bz[1])
  );
  // 2: window at 0x100
  param_slave #(.BASE_ADDR(32'h100), .DEPTH(16), .WAIT_STATES(1)) dut_c (
    .clk(clk), .rst(rst), .sel(sel[2]), .RW(rw), .addr(addr), .DataToSlave(wdata),
    .DataFromSlave(dout_c), .ready(rdy[2]), .err(er[2]), .busy(bz[2])
  );
  // 3: narrow, 4 words
  param_slave #(.DATA_W(16), .DEPTH(4), .WAIT_STATES(2)) dut_d (
    .clk(clk), .rst(rst), .sel(sel[3]), .RW(rw), .addr(addr), .DataToSlave(wdata[15:0]),
    .DataFromSlave(dout_d), .ready(rdy[3]), .err(er[3]), .busy(bz[3])
  );

  always_comb begin
    rdy_m  = 1'b0;
    err_m  = 1'b0;
    bz_m   = 1'b0;
    dout_m = '0;
    case (cur)
      0: begin rdy_m = rdy[0]; err_m = er[0]; bz_m = bz[0]; dout_m = dout_a; end
      1: begin rdy_m = rdy[1]; err_m = er[1]; bz_m = bz[1]; dout_m = dout_b; end
      2: begin rdy_m = rdy[2]; err_m = er[2]; bz_m = bz[2]; dout_m = dout_c; end
      3: begin rdy_m = rdy[3]; err_m = er[3]; bz_m = bz[3]; dout_m = {16'h0, dout_d}; end
      default: ;
    endcase
  end

  typedef struct {
    int unsigned dut;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input int unsigned d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rd, input logic e);
    vec_t v;
    int   lats [4] = '{3, 1, 2, 3};
    v.dut = d; v.rw = w; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = e; v.lat = lats[d];
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One full transfer; returns at a negedge in the idle cycle after the strobe.
  task automatic xfer(input int unsigned d, input logic w, input logic [31:0] a,
                      input logic [31:0] dt, output logic [31:0] rd, output logic e,
                      output int lat, output logic leak);
    cur = d;
    @(negedge clk);
    rw = w; addr = a; wdata = dt; sel[d] = 1'b1;
    @(posedge clk);
    #1 sel[d] = 1'b0;
    lat = 0; leak = 1'b0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rdy_m) begin
        lat = k; rd = dout_m; e = err_m;
        break;
      end
      if (err_m || dout_m != 0 || !bz_m) leak = 1'b1;
    end
    @(negedge clk);
    if (bz_m || rdy_m || err_m || dout_m != 0) leak = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e, leak, seen;
    int          lat, ns;
    int          strobe [3];

    cur = 0; rw = 0; addr = 0; wdata = 0;
    // Reset with every sel held high: reset must win.
    rst = 1'b1; sel = 4'hF;
    repeat (3) @(negedge clk);
    check("rst busy", {28'h0, bz}, 32'h0);
    check("rst ready", {28'h0, rdy}, 32'h0);
    check("rst err", {28'h0, er}, 32'h0);
    check("rst data", dout_a | dout_b | dout_c | {16'h0, dout_d}, 32'h0);
    sel = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst busy", {28'h0, bz}, 32'h0);

    addv(0, 0, 3,  0, 0, 0);
    addv(0, 1, 3,  32'hA5A5_0001, 0, 0);
    addv(0, 0, 3,  0, 32'hA5A5_0001, 0);
    addv(0, 0, 16, 0, 0, 1);
    addv(0, 1, 16, 32'h99, 0, 1);
    addv(0, 0, 0,  0, 0, 0);
    addv(0, 1, 15, 32'hDEAD_BEEF, 0, 0);
    addv(0, 0, 15, 0, 32'hDEAD_BEEF, 0);
    addv(0, 0, 3,  0, 32'hA5A5_0001, 0);
    addv(1, 0, 0,  0, 0, 0);
    addv(1, 1, 7,  32'h1234_5678, 0, 0);
    addv(1, 0, 7,  0, 32'h1234_5678, 0);
    addv(1, 0, 8,  0, 0, 0);
    addv(2, 0, 32'h100, 0, 0, 0);
    addv(2, 1, 32'h10F, 32'h0000_CAFE, 0, 0);
    addv(2, 1, 32'h110, 32'h1111_1111, 0, 1);
    addv(2, 0, 32'h10F, 0, 32'h0000_CAFE, 0);
    addv(2, 0, 32'h100, 0, 0, 0);
    addv(2, 0, 32'h0FF, 0, 0, 1);
    addv(2, 1, 32'h0FF, 32'h2222, 0, 1);
    addv(2, 0, 32'h10F, 0, 32'h0000_CAFE, 0);
    for (int i = 0; i < 4; i++) addv(3, 1, i, 32'hBEEF, 0, 0);
    for (int i = 0; i < 4; i++) addv(3, 0, i, 0, 32'hBEEF, 0);
    addv(3, 0, 4, 0, 0, 1);
    addv(3, 1, 4, 32'h1234, 0, 1);
    addv(3, 0, 0, 0, 32'hBEEF, 0);

    foreach (vecs[i]) begin
      xfer(vecs[i].dut, vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, e, lat, leak);
      check($sformatf("v%0d data", i), rd, vecs[i].rdata);
      check($sformatf("v%0d err", i), {31'h0, e}, {31'h0, vecs[i].err});
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d idle outputs", i), {31'h0, leak}, 32'h0);
    end

    // Reset in WAIT aborts a write to word 5.
    cur = 0;
    @(negedge clk);
    rw = 1'b1; addr = 5; wdata = 32'h55AA_55AA; sel[0] = 1'b1;
    @(posedge clk);
    #1 sel[0] = 1'b0;
    @(negedge clk);
    check("abort busy in wait", {31'h0, bz_m}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy after rst", {31'h0, bz_m}, 32'h0);
    check("abort ready after rst", {31'h0, rdy_m}, 32'h0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdy_m) seen = 1'b1;
    end
    check("abort no strobe", {31'h0, seen}, 32'h0);
    xfer(0, 0, 5, 0, rd, e, lat, leak);
    check("abort word5", rd, 32'h0);
    xfer(0, 0, 3, 0, rd, e, lat, leak);
    check("rst cleared word3", rd, 32'h0);

    // sel held high for three back-to-back writes to word 8, inputs scrambled in WAIT.
    cur = 0; ns = 0;
    @(negedge clk);
    rw = 1'b1; addr = 8; wdata = 32'h111; sel[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rdy_m) begin
        strobe[ns] = k;
        ns++;
        rw = 1'b1; addr = 8; wdata = (ns == 1) ? 32'h222 : 32'h333;
        if (ns == 3) begin
          sel[0] = 1'b0;
          break;
        end
      end else if (bz_m) begin
        rw = 1'b0; addr = 9; wdata = 32'hBAD;
      end
    end
    @(negedge clk);
    check("held strobes", 32'(ns), 32'd3);
    check("held gap1", 32'(strobe[1] - strobe[0]), 32'd4);
    check("held gap2", 32'(strobe[2] - strobe[1]), 32'd4);
    xfer(0, 0, 8, 0, rd, e, lat, leak);
    check("held word8", rd, 32'h333);
    xfer(0, 0, 9, 0, rd, e, lat, leak);
    check("held word9", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_slave.md
PARAM_SLAVE -- requirements
Module: param_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of DATA_W-bit storage words.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning word address of storage word 0.
REQ-005 SHALL have parameter WAIT_STATES, default 2, range 0..15, meaning extra cycles inserted before response.
REQ-006 SHALL have port clk, input, 1 bit: positive-edge clock, the only clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port sel, input, 1 bit: device selected / request.
REQ-009 SHALL have port RW, input, 1 bit: 0 = read, 1 = write.
REQ-010 SHALL have port addr, input, ADDR_W bits: word address.
REQ-011 SHALL have port DataToSlave, input, DATA_W bits: write data.
REQ-012 SHALL have port DataFromSlave, output, DATA_W bits: read data.
REQ-013 SHALL have port ready, output, 1 bit: one-cycle transfer-complete strobe.
REQ-014 SHALL have port err, output, 1 bit: address-out-of-range flag, valid with ready.
REQ-015 SHALL have port busy, output, 1 bit: high while a transfer is in progress.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 In IDLE, sel=1 at a clock edge SHALL accept the request: capture RW, addr, DataToSlave, and leave IDLE.
REQ-018 On acceptance, the FSM SHALL go to WAIT if WAIT_STATES>0, otherwise directly to RESP.
REQ-019 WAIT SHALL last exactly WAIT_STATES cycles, counted by a down-counter loaded at acceptance, then go to RESP.
REQ-020 RESP SHALL last exactly one cycle, with ready=1, then return to IDLE.
REQ-021 ready SHALL first be high in cycle WAIT_STATES+1 after the accepting edge; end-to-end latency SHALL be WAIT_STATES+1 cycles.
REQ-022 Inputs sel/RW/addr/DataToSlave SHALL be ignored outside IDLE; only captured values are used.
REQ-023 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-024 A request SHALL be in range when BASE_ADDR <= addr < BASE_ADDR+DEPTH, compared at ADDR_W width with no wrap-around.
REQ-025 Word index SHALL be addr-BASE_ADDR, truncated to clog2(DEPTH) bits.
REQ-026 An in-range write SHALL update the storage word at the edge ending RESP.
REQ-027 An in-range read SHALL drive that word on DataFromSlave during RESP.
REQ-028 Out of range: err=1 during RESP, no storage change, DataFromSlave = 0.
REQ-029 DataFromSlave SHALL be 0 in every cycle except an in-range read RESP.
REQ-030 err SHALL be 0 whenever ready=0.
REQ-031 sel held high through RESP SHALL start a new transfer at the first IDLE edge, giving one idle cycle between strobes.
REQ-032 A read following a write to the same word SHALL return the new data.

Reset
REQ-033 rst=1 at an edge SHALL force IDLE, clear the wait counter and captured fields, and zero all storage words.
REQ-034 During and after reset: ready=0, err=0, busy=0, DataFromSlave=0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer: no storage write, no ready strobe.
REQ-036 rst SHALL take priority over sel at the same edge.

Structure
REQ-037 Package slv_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-038 Storage SHALL live in one sub-module, slv_mem_array, a DEPTH x DATA_W register file: synchronous write, combinational read, synchronous clear.
REQ-039 Target size SHALL be 120-400 RTL lines.

Verification
REQ-040 Bench SHALL check: reset, then write addr=3, data=0xA5A5_0001, WAIT_STATES=2 -> ready in 3rd cycle after accept, err=0; read addr=3 -> DataFromSlave=0xA5A5_0001.
REQ-041 Bench SHALL check: WAIT_STATES=0, read addr=0 after reset -> ready in cycle after accept, DataFromSlave=0.
REQ-042 Bench SHALL check: BASE_ADDR=0x100, DEPTH=16, write addr=0x110 -> err=1 with ready; read addr=0x10F -> err=0, data unchanged; addr=0xFF -> err=1.
REQ-043 Bench SHALL check: write addr=5 in progress, rst in WAIT -> no ready, busy=0; read addr=5 -> 0.
REQ-044 Bench SHALL check: sel held high for 3 transfers -> ready strobes spaced WAIT_STATES+2 cycles; input changes during WAIT ignored.
REQ-045 Bench SHALL check: DATA_W=16, DEPTH=4, write 0xBEEF to words 0..3 -> all read back 0xBEEF; addr=4 -> err=1.
